spi_master_cfg: RTL and testbench

SPI_MASTER_CFG -- requirements
Module: spi_master_cfg

---
 rtl/spi_master_cfg.sv | 176 +++++++++++++++++
 tb/tb_spi_master_cfg.sv | 313 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_master_cfg.sv
// rtl/spi_master_cfg.sv - configurable single-word SPI master (mode 0-3, MSB/LSB first, multi-CS)
//
// Ports:
//   clk, rst        system clock (rising edge), asynchronous active-high reset
//   start           transfer request, honoured only while idle
//   cs_sel          chip-select index; values >= NUM_CS run a transfer with no CS asserted
//   cpol, cpha      SPI clock polarity / phase for the transfer
//   lsb_first       1 = shift LSB first, 0 = MSB first
//   clk_div         SCLK half-period is clk_div+1 clk cycles
//   tx_data         word to transmit
//   rx_data         last received word, updated together with done
//   busy            transfer in progress
//   done            one-cycle completion pulse
//   spi_sclk, spi_mosi, spi_miso, spi_cs_n   SPI bus (spi_cs_n active-low)
module spi_master_cfg #(
  parameter int DATA_W = 8,
  parameter int NUM_CS = 2,
  parameter int DIV_W  = 8,
  localparam int CS_W  = (NUM_CS > 1) ? $clog2(NUM_CS) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [CS_W-1:0]   cs_sel,
  input  logic              cpol,
  input  logic              cpha,
  input  logic              lsb_first,
  input  logic [DIV_W-1:0]  clk_div,
  input  logic [DATA_W-1:0] tx_data,
  output logic [DATA_W-1:0] rx_data,
  output logic              busy,
  output logic              done,
  output logic              spi_sclk,
  output logic              spi_mosi,
  input  logic              spi_miso,
  output logic [NUM_CS-1:0] spi_cs_n
);

  localparam int EDGE_W = $clog2(2 * DATA_W + 1);

  typedef enum logic [1:0] {IDLE, SETUP, XFER, HOLD} state_t;

  state_t             state, state_nxt;
  logic [DIV_W-1:0]   div_q;
  logic [DIV_W-1:0]   hp_cnt;
  logic [EDGE_W-1:0]  edge_cnt;
  logic               cpha_q;
  logic               lsb_q;
  logic [DATA_W-1:0]  tx_sh;
  logic [DATA_W-1:0]  rx_sh;
  logic [DATA_W-1:0]  rx_q;
  logic               sclk_q;
  logic               mosi_q;
  logic               done_q;
  logic [NUM_CS-1:0]  cs_n_q;
  logic [NUM_CS-1:0]  cs_dec;

  logic hp_end;
  logic last_edge;
  logic leading;
  logic in_edge;
  logic sample_now;
  logic shift_now;
  logic first_bit;

  // Half-period counter runs down from the latched divider and reloads, so
  // the maximum divider value never needs a wider counter.
  assign hp_end    = (hp_cnt == '0);
  // edge_cnt holds the number of SCLK edges already produced; the edge about
  // to happen is edge_cnt+1, which is a leading edge when edge_cnt is even.
  assign last_edge = (edge_cnt == EDGE_W'(2 * DATA_W - 1));
  assign leading   = ~edge_cnt[0];
  assign in_edge   = ((state == SETUP) || (state == XFER)) && hp_end;
  assign sample_now = in_edge && (leading ^ cpha_q);
  // cpha=0 already drove the first bit at start, so it shifts on trailing
  // edges except the last; cpha=1 drives every bit on a leading edge.
  assign shift_now  = in_edge && (cpha_q ? leading : (!leading && !last_edge));
  assign first_bit  = lsb_first ? tx_data[0] : tx_data[DATA_W-1];

  always_comb begin
    cs_dec = '1;
    for (int i = 0; i < NUM_CS; i++) begin
      if (cs_sel == CS_W'(i)) cs_dec[i] = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = SETUP;
      SETUP:   if (hp_end) state_nxt = XFER;
      XFER:    if (hp_end && last_edge) state_nxt = HOLD;
      HOLD:    if (hp_end) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div_q    <= '0;
      hp_cnt   <= '0;
      edge_cnt <= '0;
      cpha_q   <= 1'b0;
      lsb_q    <= 1'b0;
      tx_sh    <= '0;
      rx_sh    <= '0;
      rx_q     <= '0;
      sclk_q   <= 1'b0;
      mosi_q   <= 1'b0;
      done_q   <= 1'b0;
      cs_n_q   <= '1;
    end else begin
      done_q <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            div_q    <= clk_div;
            hp_cnt   <= clk_div;
            edge_cnt <= '0;
            cpha_q   <= cpha;
            lsb_q    <= lsb_first;
            rx_sh    <= '0;
            sclk_q   <= cpol;
            cs_n_q   <= cs_dec;
            if (!cpha) begin
              mosi_q <= first_bit;
              tx_sh  <= lsb_first ? (tx_data >> 1) : (tx_data << 1);
            end else begin
              tx_sh  <= tx_data;
            end
          end
        end
        SETUP, XFER: begin
          if (hp_end) begin
            hp_cnt   <= div_q;
            sclk_q   <= ~sclk_q;
            edge_cnt <= edge_cnt + 1'b1;
          end else begin
            hp_cnt   <= hp_cnt - 1'b1;
          end
          if (sample_now) begin
            rx_sh <= lsb_q ? {spi_miso, rx_sh[DATA_W-1:1]}
                           : {rx_sh[DATA_W-2:0], spi_miso};
          end
          if (shift_now) begin
            mosi_q <= lsb_q ? tx_sh[0] : tx_sh[DATA_W-1];
            tx_sh  <= lsb_q ? (tx_sh >> 1) : (tx_sh << 1);
          end
        end
        HOLD: begin
          if (hp_end) begin
            cs_n_q <= '1;
            rx_q   <= rx_sh;
            done_q <= 1'b1;
          end else begin
            hp_cnt <= hp_cnt - 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign busy     = (state != IDLE);
  assign done     = done_q;
  assign rx_data  = rx_q;
  assign spi_sclk = sclk_q;
  assign spi_mosi = mosi_q;
  assign spi_cs_n = cs_n_q;

endmodule

// File: tb/tb_spi_master_cfg.sv
// tb/tb_spi_master_cfg.sv - scoreboard bench for spi_master_cfg with a SPI slave/bus monitor
module tb_spi_master_cfg;
  localparam int DW  = 8;
  localparam int NCS = 3;
  localparam int DVW = 8;
  localparam int CSW = 2;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic           start = 1'b0;
  logic [CSW-1:0] cs_sel = '0;
  logic           cpol = 1'b0;
  logic           cpha = 1'b0;
  logic           lsb_first = 1'b0;
  logic [DVW-1:0] clk_div = '0;
  logic [DW-1:0]  tx_data = '0;
  logic [DW-1:0]  rx_data;
  logic           busy;
  logic           done;
  logic           spi_sclk;
  logic           spi_mosi;
  logic           spi_miso;
  logic [NCS-1:0] spi_cs_n;

  logic           loop_mode = 1'b1;
  logic           slave_bit = 1'b0;
  logic [DW-1:0]  slave_word = '0;
  logic           cur_cpha = 1'b0;
  logic           cur_lsb = 1'b0;
  logic           gap_check = 1'b0;

  int n_checks = 0;
  int n_fail = 0;

  typedef struct {
    logic [DW-1:0]  rx;
    logic [DW-1:0]  seq;
    logic [NCS-1:0] cs_n;
    int             cs_low;
    int             busy_cyc;
    int             half;
    logic           pol;
  } exp_t;

  exp_t exp_q[$];

  assign spi_miso = loop_mode ? spi_mosi : slave_bit;

  spi_master_cfg #(.DATA_W(DW), .NUM_CS(NCS), .DIV_W(DVW)) dut (
    .clk(clk), .rst(rst), .start(start), .cs_sel(cs_sel), .cpol(cpol),
    .cpha(cpha), .lsb_first(lsb_first), .clk_div(clk_div), .tx_data(tx_data),
    .rx_data(rx_data), .busy(busy), .done(done), .spi_sclk(spi_sclk),
    .spi_mosi(spi_mosi), .spi_miso(spi_miso), .spi_cs_n(spi_cs_n)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [DW-1:0] bitrev(input logic [DW-1:0] v);
    logic [DW-1:0] r;
    for (int i = 0; i < DW; i++) r[i] = v[DW-1-i];
    return r;
  endfunction

  // Bit i of the slave's word in wire order.
  function automatic logic sbit(input int i);
    return cur_lsb ? slave_word[i] : slave_word[DW-1-i];
  endfunction

  // Reference model: what one complete transfer must look like on the bus.
  function automatic exp_t model(input logic [DW-1:0] tx, input int cs, input logic pol,
                                 input logic lsb, input int div, input logic loop,
                                 input logic [DW-1:0] sw);
    exp_t e;
    e.rx       = loop ? tx : sw;
    e.seq      = lsb ? bitrev(tx) : tx;
    e.half     = div + 1;
    e.busy_cyc = (2 * DW + 1) * (div + 1);
    e.cs_n     = '1;
    if (cs < NCS) e.cs_n[cs] = 1'b0;
    e.cs_low   = (cs < NCS) ? e.busy_cyc : 0;
    e.pol      = pol;
    return e;
  endfunction

  // Monitor / slave: watches the bus every falling clk edge, plays the slave,
  // and scores each completed transfer against the head of the queue.
  initial begin : monitor
    exp_t          e;
    logic          in_xfer = 1'b0;
    logic          prev_sclk = 1'b0;
    logic          prev_done = 1'b0;
    logic          setup_sclk = 1'b0;
    logic          cs_var = 1'b0;
    logic [NCS-1:0] cs_seen = '1;
    logic [DW-1:0] prev_rx = '0;
    logic [DW-1:0] cap = '0;
    int            nbits = 0, ecount = 0, since = 0, bad_half = 0;
    int            cs_low = 0, busy_cyc = 0, idle_run = 0, sidx = 0;
    forever begin
      @(negedge clk);
      if (rst) begin
        in_xfer   = 1'b0;
        idle_run  = 0;
        prev_done = 1'b0;
        prev_rx   = rx_data;
      end else begin
        if (!done) chk("rx_hold", rx_data, prev_rx);
        prev_rx = rx_data;
        if (prev_done) chk("done_width", done, 0);
        if (busy) begin
          if (!in_xfer) begin
            if (gap_check) chk("b2b_gap", idle_run, 1);
            in_xfer = 1'b1; ecount = 0; since = 0; bad_half = 0; cs_low = 0;
            busy_cyc = 0; cs_var = 1'b0; cs_seen = spi_cs_n; cap = '0; nbits = 0;
            prev_sclk = spi_sclk; setup_sclk = spi_sclk; sidx = 0;
            if (!cur_cpha) begin
              slave_bit = sbit(0);
              sidx = 1;
            end
          end else begin
            since++;
            if (spi_sclk !== prev_sclk) begin
              ecount++;
              if (exp_q.size() > 0 && since != exp_q[0].half) bad_half++;
              since = 0;
              prev_sclk = spi_sclk;
              if (cur_cpha ? (ecount % 2 == 0) : (ecount % 2 == 1)) begin
                cap = {cap[DW-2:0], spi_mosi};
                nbits++;
              end
              if (cur_cpha ? (ecount % 2 == 1) : (ecount % 2 == 0 && ecount < 2 * DW)) begin
                if (sidx < DW) slave_bit = sbit(sidx);
                sidx++;
              end
            end
          end
          busy_cyc++;
          if (spi_cs_n !== '1) cs_low++;
          if (spi_cs_n !== cs_seen) cs_var = 1'b1;
          idle_run = 0;
        end else begin
          idle_run++;
          if (done) begin
            in_xfer = 1'b0;
            if (exp_q.size() == 0) begin
              chk("unexpected_done", done, 0);
            end else begin
              e = exp_q.pop_front();
              chk("rx_data", rx_data, e.rx);
              chk("mosi_bits", cap, e.seq);
              chk("mosi_bit_count", nbits, DW);
              chk("sclk_edges", ecount, 2 * DW);
              chk("half_period_errs", bad_half, 0);
              chk("cs_pattern", cs_seen, e.cs_n);
              chk("cs_stable", cs_var, 0);
              chk("cs_low_cycles", cs_low, e.cs_low);
              chk("busy_cycles", busy_cyc, e.busy_cyc);
              chk("setup_sclk", setup_sclk, e.pol);
              chk("idle_sclk", spi_sclk, e.pol);
              chk("cs_release", spi_cs_n, {NCS{1'b1}});
            end
          end else if (in_xfer) begin
            chk("busy_fell_without_done", done, 1);
            in_xfer = 1'b0;
          end
        end
        prev_done = done;
      end
    end
  end

  task automatic wait_idle();
    bit ok = 1'b0;
    for (int i = 0; i < 20000 && !ok; i++) begin
      @(negedge clk);
      if (!busy) ok = 1'b1;
    end
    if (!ok) chk("idle_timeout", busy, 0);
  endtask

  task automatic run_xfer(input logic [DW-1:0] tx, input int cs, input logic pol,
                          input logic pha, input logic lsb, input int div,
                          input logic loop, input logic [DW-1:0] sw, input bit junk);
    bit got = 1'b0;
    int budget = (2 * DW + 1) * (div + 1) + 40;
    wait_idle();
    cur_cpha = pha; cur_lsb = lsb; loop_mode = loop; slave_word = sw;
    exp_q.push_back(model(tx, cs, pol, lsb, div, loop, sw));
    tx_data = tx; cs_sel = CSW'(cs); cpol = pol; cpha = pha; lsb_first = lsb;
    clk_div = DVW'(div); start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("busy_after_start", busy, 1);
    // Scramble the inputs: the transfer in flight must not notice.
    tx_data = DW'($urandom); cs_sel = CSW'($urandom); cpol = 1'($urandom);
    cpha = 1'($urandom); lsb_first = 1'($urandom); clk_div = DVW'($urandom);
    if (junk) begin
      repeat (2) @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
    end
    for (int i = 0; i < budget && !got; i++) begin
      @(negedge clk);
      if (done) got = 1'b1;
    end
    chk("done_seen", got, 1);
    @(negedge clk);
    chk("no_queued_start", busy, 0);
  endtask

  task automatic run_b2b(input int n, input int div);
    exp_t e;
    int dcount = 0;
    logic [DW-1:0] tx = DW'($urandom);
    logic [DW-1:0] sw = DW'($urandom);
    wait_idle();
    cur_cpha = 1'b1; cur_lsb = 1'b0; loop_mode = 1'b0; slave_word = sw;
    e = model(tx, 2, 1'b0, 1'b0, div, 1'b0, sw);
    for (int i = 0; i < n; i++) exp_q.push_back(e);
    tx_data = tx; cs_sel = 2'd2; cpol = 1'b0; cpha = 1'b1; lsb_first = 1'b0;
    clk_div = DVW'(div); start = 1'b1;
    @(negedge clk);
    #1 gap_check = 1'b1;
    for (int i = 0; i < n * ((2 * DW + 1) * (div + 1) + 10) && dcount < n; i++) begin
      @(negedge clk);
      if (done) begin
        dcount++;
        if (dcount == n) start = 1'b0;
      end
    end
    start = 1'b0;
    chk("b2b_done_count", dcount, n);
    @(negedge clk);
    gap_check = 1'b0;
    chk("b2b_stopped", busy, 0);
  endtask

  task automatic run_reset_abort();
    int edges = 0;
    logic ps;
    wait_idle();
    cur_cpha = 1'b0; cur_lsb = 1'b0; loop_mode = 1'b1;
    tx_data = 8'hFF; cs_sel = 2'd1; cpol = 1'b0; cpha = 1'b0; lsb_first = 1'b0;
    clk_div = DVW'(1); start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    ps = spi_sclk;
    for (int i = 0; i < 200 && edges < 5; i++) begin
      @(negedge clk);
      if (spi_sclk !== ps) edges++;
      ps = spi_sclk;
    end
    chk("abort_edges_reached", edges, 5);
    #2 rst = 1'b1;
    #1;
    chk("abort_cs_n", spi_cs_n, {NCS{1'b1}});
    chk("abort_busy", busy, 0);
    chk("abort_rx", rx_data, 0);
    chk("abort_done", done, 0);
    chk("abort_sclk", spi_sclk, 0);
    chk("abort_mosi", spi_mosi, 0);
    repeat (2) @(negedge clk);
    chk("abort_done_later", done, 0);
    #2 rst = 1'b0;
  endtask

  initial begin : stim
    logic [DW-1:0] tx, sw;
    repeat (3) @(negedge clk);
    chk("rst_cs_n", spi_cs_n, {NCS{1'b1}});
    chk("rst_sclk", spi_sclk, 0);
    chk("rst_mosi", spi_mosi, 0);
    chk("rst_rx", rx_data, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    #2 rst = 1'b0;
    @(negedge clk);

    run_xfer(8'hA5, 0, 1'b0, 1'b0, 1'b0, 0, 1'b1, 8'h00, 1'b0);
    run_xfer(8'h3C, 0, 1'b1, 1'b1, 1'b0, 3, 1'b0, 8'hC3, 1'b0);
    chk("mode3_idle_high", spi_sclk, 1);
    run_xfer(8'h01, 0, 1'b0, 1'b1, 1'b1, 0, 1'b1, 8'h00, 1'b0);
    run_xfer(8'h96, 1, 1'b0, 1'b0, 1'b0, 1, 1'b1, 8'h00, 1'b1);
    run_xfer(8'h5A, 3, 1'b1, 1'b0, 1'b1, 2, 1'b0, 8'h69, 1'b0);
    run_xfer(8'hE7, 2, 1'b0, 1'b1, 1'b0, 255, 1'b0, 8'h1D, 1'b0);
    run_b2b(3, 1);
    run_xfer(8'h81, 1, 1'b0, 1'b0, 1'b0, 0, 1'b1, 8'h00, 1'b0);
    run_reset_abort();
    run_xfer(8'hC6, 1, 1'b0, 1'b0, 1'b0, 0, 1'b1, 8'h00, 1'b0);

    for (int t = 0; t < 20; t++) begin
      tx = DW'($urandom);
      sw = DW'($urandom);
      run_xfer(tx, $urandom_range(0, 3), 1'($urandom), 1'($urandom), 1'($urandom),
               $urandom_range(0, 5), 1'($urandom), sw, ($urandom_range(0, 3) == 0));
    end

    repeat (10) @(negedge clk);
    chk("scoreboard_empty", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
